// File: rtl/core_types.sv
// Shared frontend types: fetch FSM encoding and the instruction-buffer entry.
package core_types;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned PC_WIDTH    = 32;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                   valid;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } instr_info_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch unit: holds the PC, issues one aligned packet request at a time to the
// ICache and presents the returned packet to the instruction buffer for one cycle.
module instr_fetch_unit
  import core_types::*;
#(
  parameter int unsigned              IF_WIDTH   = 2,
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = 32'h1c000000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            icache_rreq_o,
  output logic [ADDR_WIDTH-1:0]           icache_raddr_o,
  input  logic                            icache_rreq_ready_i,
  input  logic                            icache_rvalid_i,
  input  logic [IF_WIDTH*INSTR_WIDTH-1:0] icache_rdata_i,
  input  logic                            frontend_stallreq_i,
  input  logic                            backend_flush_i,
  input  logic [ADDR_WIDTH-1:0]           backend_target_i,
  output instr_info_t [IF_WIDTH-1:0]      instr_o
);

  localparam int unsigned IDX_W = $clog2(IF_WIDTH);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned STEP  = IF_WIDTH * 4;

  fetch_state_t               r_state;
  fetch_state_t               w_state_next;
  logic [ADDR_WIDTH-1:0]      r_pc;
  logic [ADDR_WIDTH-1:0]      w_pc_next;
  logic [ADDR_WIDTH-1:0]      w_pc_aligned;
  logic                       w_pkt_wr;
  logic [IDX_W-1:0]           w_lane_idx;
  logic [IF_WIDTH-1:0]        w_lane_mask;
  instr_info_t [IF_WIDTH-1:0] w_pkt;
  instr_info_t [IF_WIDTH-1:0] r_instr;
  logic                       w_unused_pc_bits;

  // PC alignment: packet base and index of the first lane being fetched
  assign w_pc_aligned     = {r_pc[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign w_lane_idx       = r_pc[OFF_W-1:2];
  assign w_unused_pc_bits = ^r_pc[1:0];

  // Lane mask: lanes before the PC's slot in the packet are not part of the stream
  always_comb begin
    w_lane_mask = '0;
    for (int i = 0; i < int'(IF_WIDTH); i++) begin
      w_lane_mask[i] = (IDX_W'(i) >= w_lane_idx);
    end
  end

  // Packet formatting: invalid lanes are forced to all zero
  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < int'(IF_WIDTH); i++) begin
      if (w_lane_mask[i]) begin
        w_pkt[i].valid = 1'b1;
        w_pkt[i].pc    = PC_WIDTH'(w_pc_aligned + ADDR_WIDTH'(4 * i));
        w_pkt[i].instr = icache_rdata_i[INSTR_WIDTH*i +: INSTR_WIDTH];
      end
    end
  end

  // State register and fetch PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state logic: flush always wins the PC, a response in WAIT is only kept without flush
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_pkt_wr     = 1'b0;
    unique case (r_state)
      REQ: begin
        if (backend_flush_i) begin
          w_pc_next = backend_target_i;
        end else if (icache_rreq_o && icache_rreq_ready_i) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (backend_flush_i) begin
          w_pc_next    = backend_target_i;
          w_state_next = icache_rvalid_i ? REQ : DISCARD;
        end else if (icache_rvalid_i) begin
          w_pkt_wr     = 1'b1;
          w_pc_next    = w_pc_aligned + ADDR_WIDTH'(STEP);
          w_state_next = REQ;
        end
      end
      DISCARD: begin
        if (backend_flush_i) begin
          w_pc_next = backend_target_i;
        end
        if (icache_rvalid_i) begin
          w_state_next = REQ;
        end
      end
      default: begin
        w_state_next = REQ;
      end
    endcase
  end

  // Request outputs: combinational, suppressed during reset, stall and flush
  always_comb begin
    icache_rreq_o  = rst_n && (r_state == REQ) && !frontend_stallreq_i && !backend_flush_i;
    icache_raddr_o = w_pc_aligned;
  end

  // Output packet register: holds a packet for exactly one cycle, zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
    end else begin
      r_instr <= w_pkt_wr ? w_pkt : '0;
    end
  end

  assign instr_o = r_instr;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Frontend producer for the instruction buffer.
- Holds the fetch PC, issues one aligned fetch-packet request to the ICache, and converts the returned packet into IF_WIDTH instr_info_t entries with per-lane valid bits.
- Obeys the buffer's stall request and redirects on a backend flush, dropping any stale in-flight response.

Parameters:
- IF_WIDTH, 2, instructions per fetch packet; power of two.
- RESET_PC, 32'h1c000000, PC loaded at reset.
- ADDR_WIDTH, 32, PC and address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- icache_rreq_o  out  1  fetch request valid.
- icache_raddr_o  out  ADDR_WIDTH  packet-aligned fetch address; low $clog2(IF_WIDTH)+2 bits are zero.
- icache_rreq_ready_i  in  1  ICache accepts the request this cycle.
- icache_rvalid_i  in  1  response data valid, one cycle.
- icache_rdata_i  in  IF_WIDTH*32  packet data; lane i is at bits [32i+31:32i].
- frontend_stallreq_i  in  1  instruction buffer near full.
- backend_flush_i  in  1  redirect request.
- backend_target_i  in  ADDR_WIDTH  redirect PC.
- instr_o  out  instr_info_t[IF_WIDTH]  registered packet to the instruction buffer.

Behaviour:
- Reset (async, rst_n low):
  - state=REQ, pc=RESET_PC.
  - instr_o all zero.
  - icache_rreq_o=0 while in reset.
- FSM states: REQ, WAIT, DISCARD.
- Request output:
  - icache_rreq_o = (state==REQ) && !frontend_stallreq_i && !backend_flush_i. Combinational.
  - icache_raddr_o = pc with offset bits cleared.
- State transitions, in priority order:
  - REQ: flush -> pc=target, stay REQ, no request issued. Else handshake (rreq&&ready) -> WAIT. Else stay REQ.
  - WAIT: flush with no rvalid -> pc=target, go DISCARD. Flush with rvalid -> pc=target, go REQ; response dropped. rvalid with no flush -> write packet, pc=aligned(pc)+IF_WIDTH*4, go REQ.
  - DISCARD: rvalid -> REQ; data dropped. A flush in DISCARD updates pc=target. If flush and rvalid coincide, go REQ with the new pc.
- Packet write, registered:
  - Happens on the cycle after rvalid.
  - Lane i: valid = (i >= pc offset index); pc = aligned(pc)+4i; instr = lane i data.
  - Invalid lanes are driven all zero.
- instr_o is zero in every other cycle. The buffer writes whenever a lane is valid, so each packet is presented for exactly one cycle.
- Flush zeroes instr_o on the following edge. A packet already registered in the flush cycle is not cleared retroactively; the buffer discards it under the same flush.
- Stall:
  - Blocks only new requests.
  - An in-flight response is always delivered; the buffer's slack of at least 4 entries covers one packet.
  - Stall never drops or delays instr_o.
- Latency and throughput:
  - Handshake at cycle t, rvalid at t+k -> instr_o valid at t+k+1.
  - Next request possible at t+k+1.
  - At most one outstanding request at any time.
- Wrap-around: PC arithmetic is modulo 2^ADDR_WIDTH, with no special handling.
- Invariants:
  - The ICache never sees a second request before the response to the first.
  - A response is never written when state==DISCARD, or in the cycle the response coincides with a flush.

Decomposition:
- Shared core_types package:
  - Fetch FSM enum fetch_state_t {REQ, WAIT, DISCARD}.
  - INSTR_WIDTH=32.
  - The existing instr_info_t (valid, pc, instr).
- Single module. PC alignment and lane-mask generation are small combinational blocks; no sub-module.

Test Plan:
1. Reset then ready=1, rvalid two cycles after the handshake -> first raddr=1c000000; instr_o valid lanes 0,1 with pc 1c000000/1c000004; next raddr=1c000008.
2. Flush to 1c000104 while idle in REQ -> next request raddr=1c000100; response gives lane0 valid=0 and lane1 valid=1 with pc=1c000104.
3. Flush in WAIT, rvalid 3 cycles later -> DISCARD; stale data never reaches instr_o; next raddr=new target aligned.
4. Flush coinciding with rvalid -> instr_o stays zero; FSM goes straight to REQ with the target pc.
5. frontend_stallreq_i asserted while in WAIT -> response still written on the cycle after rvalid; icache_rreq_o stays 0 until stall deasserts, then raddr=pc+8.
6. Assert rst_n low mid-WAIT, then release and deliver a late rvalid -> instr_o stays zero; the first request after release uses RESET_PC. The bench must not deliver the stale response in the same cycle as the first new handshake.
